// File: rtl/id_stage.sv
`default_nettype none
// id_stage: MIPS decode stage (fetch/EXE handshake, operand read, branch/jump resolution, one delay slot).
// Optional macro ID_EXC_EN adds SYSCALL/BREAK/reserved-instruction reporting. Rev 1.0
module id_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid_in,
  input  logic [DATA_W-1:0]     if_PC_in,
  input  logic [DATA_W-1:0]     if_NPC_in,
  input  logic [DATA_W-1:0]     if_NNPC_in,
  input  logic [31:0]           if_Instruct_in,
  output logic                  id_allowin_out,
  output logic [DATA_W-1:0]     id_nextPC_out,
  output logic [REG_ADDR_W-1:0] id_rs_addr_out,
  output logic [REG_ADDR_W-1:0] id_rt_addr_out,
  input  logic [DATA_W-1:0]     rs_rdata_in,
  input  logic [DATA_W-1:0]     rt_rdata_in,
  input  logic                  id_stall_in,
  input  logic                  exe_allowin_in,
  output logic                  id_valid_out,
  output logic [DATA_W-1:0]     id_PC_out,
  output logic [31:0]           id_Instruct_out,
  output logic [DATA_W-1:0]     id_rs_data_out,
  output logic [DATA_W-1:0]     id_rt_data_out,
  output logic [DATA_W-1:0]     id_imm_out,
  output logic [DATA_W-1:0]     id_link_out,
  output logic [REG_ADDR_W-1:0] id_wreg_out,
  output logic                  id_wen_out,
`ifdef ID_EXC_EN
  output logic                  id_exc_out,
  output logic [7:0]            id_exccode_out,
`endif
  output logic                  id_in_ds_out
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_COP0 = 6'h10;
  localparam logic [5:0] F_JR       = 6'h08, F_JALR    = 6'h09, F_SYSCALL = 6'h0C, F_BREAK = 6'h0D;
  localparam logic [REG_ADDR_W-1:0] LINK_REG = {REG_ADDR_W{1'b1}};

  logic              valid_r, in_ds_r;
  logic [DATA_W-1:0] pc_r, npc_r, nnpc_r;
  logic [31:0]       instr_r;

  logic ready, allowin, leave;
  assign ready   = !id_stall_in;
  assign allowin = !rst_n || !valid_r || (ready && exe_allowin_in);
  assign leave   = valid_r && ready && exe_allowin_in;

  logic [5:0]            op, funct;
  logic [4:0]            rs_f, rt_f, rd_f;
  logic [DATA_W-1:0]     sext_imm, br_target, j_target;
  assign op        = instr_r[31:26];
  assign funct     = instr_r[5:0];
  assign rs_f      = instr_r[25:21];
  assign rt_f      = instr_r[20:16];
  assign rd_f      = instr_r[15:11];
  assign sext_imm  = {{(DATA_W-16){instr_r[15]}}, instr_r[15:0]};
  assign br_target = npc_r + {sext_imm[DATA_W-3:0], 2'b00};
  assign j_target  = {npc_r[DATA_W-1:DATA_W-4], instr_r[25:0], 2'b00};

  logic                  is_br, cond, wen, zext, known;
  logic [DATA_W-1:0]     target;
  logic [REG_ADDR_W-1:0] wreg;
  logic [7:0]            exc_code;

  always_comb begin
    is_br    = 1'b0;
    cond     = 1'b0;
    target   = br_target;
    wen      = 1'b0;
    wreg     = rt_f;
    zext     = 1'b0;
    known    = 1'b1;
    exc_code = 8'h00;
    case (op)
      OP_SPECIAL: begin
        wreg = rd_f;
        case (funct)
          F_JR:      begin is_br = 1'b1; cond = 1'b1; target = rs_rdata_in; end
          F_JALR:    begin is_br = 1'b1; cond = 1'b1; target = rs_rdata_in; wen = 1'b1; end
          F_SYSCALL: exc_code = 8'h08;
          F_BREAK:   exc_code = 8'h09;
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B:
            wen = 1'b1;
          6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: ;
          default: known = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        // rt[4] selects the linking forms, rt[0] selects >= 0 versus < 0
        case (rt_f)
          5'h00, 5'h01, 5'h10, 5'h11: begin
            is_br = 1'b1;
            cond  = rt_f[0] ? !rs_rdata_in[DATA_W-1] : rs_rdata_in[DATA_W-1];
            wen   = rt_f[4];
            wreg  = LINK_REG;
          end
          default: known = 1'b0;
        endcase
      end
      OP_J:    begin is_br = 1'b1; cond = 1'b1; target = j_target; end
      OP_JAL:  begin is_br = 1'b1; cond = 1'b1; target = j_target; wen = 1'b1; wreg = LINK_REG; end
      OP_BEQ:  begin is_br = 1'b1; cond = (rs_rdata_in == rt_rdata_in); end
      OP_BNE:  begin is_br = 1'b1; cond = (rs_rdata_in != rt_rdata_in); end
      OP_BLEZ: begin is_br = 1'b1; cond = rs_rdata_in[DATA_W-1] || (rs_rdata_in == '0); end
      OP_BGTZ: begin is_br = 1'b1; cond = !rs_rdata_in[DATA_W-1] && (rs_rdata_in != '0); end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0F: wen = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI: begin wen = 1'b1; zext = 1'b1; end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: wen = 1'b1;
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: ;
      OP_COP0: begin
        case (rs_f)
          5'h00:   wen = 1'b1;
          5'h04:   ;
          5'h10:   known = (funct == 6'h18);
          default: known = 1'b0;
        endcase
      end
      default: known = 1'b0;
    endcase
  end

  logic exc;
`ifdef ID_EXC_EN
  assign exc            = !known || (exc_code != 8'h00);
  assign id_exc_out     = valid_r && exc;
  assign id_exccode_out = !(valid_r && exc) ? 8'h00 : (known ? exc_code : 8'h0A);
`else
  logic unused_dec;
  assign exc        = 1'b0;
  assign unused_dec = ^{known, exc_code};
`endif

  logic taken;
  assign taken         = valid_r && is_br && cond && !exc;
  assign id_nextPC_out = taken ? target : if_NPC_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      in_ds_r <= 1'b0;
      pc_r    <= '0;
      npc_r   <= '0;
      nnpc_r  <= '0;
      instr_r <= '0;
    end else begin
      if (leave)
        in_ds_r <= is_br;
      if (allowin)
        valid_r <= if_valid_in;
      if (allowin && if_valid_in) begin
        pc_r    <= if_PC_in;
        npc_r   <= if_NPC_in;
        nnpc_r  <= if_NNPC_in;
        instr_r <= if_Instruct_in;
      end
    end
  end

  assign id_allowin_out  = allowin;
  assign id_valid_out    = valid_r && ready;
  assign id_rs_addr_out  = rs_f;
  assign id_rt_addr_out  = rt_f;
  assign id_PC_out       = pc_r;
  assign id_Instruct_out = instr_r;
  assign id_rs_data_out  = rs_rdata_in;
  assign id_rt_data_out  = rt_rdata_in;
  assign id_imm_out      = zext ? {{(DATA_W-16){1'b0}}, instr_r[15:0]} : sext_imm;
  assign id_link_out     = nnpc_r;
  assign id_wreg_out     = wreg;
  assign id_wen_out      = wen && !exc;
  assign id_in_ds_out    = in_ds_r;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// tb_id_stage: directed scenarios plus randomized traffic checked against an instruction-level model.
module tb_id_stage;
  logic        clk, rst_n;
  logic        if_valid_in, id_stall_in, exe_allowin_in;
  logic [31:0] if_PC_in, if_NPC_in, if_NNPC_in, if_Instruct_in;
  logic        id_allowin_out, id_valid_out, id_wen_out, id_in_ds_out;
  logic [31:0] id_nextPC_out, id_PC_out, id_Instruct_out, id_rs_data_out, id_rt_data_out;
  logic [31:0] id_imm_out, id_link_out, rs_rdata_in, rt_rdata_in;
  logic [4:0]  id_rs_addr_out, id_rt_addr_out, id_wreg_out;

  logic [31:0] regs [32];
  assign rs_rdata_in = regs[id_rs_addr_out];
  assign rt_rdata_in = regs[id_rt_addr_out];

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid_in(if_valid_in), .if_PC_in(if_PC_in),
    .if_NPC_in(if_NPC_in), .if_NNPC_in(if_NNPC_in), .if_Instruct_in(if_Instruct_in),
    .id_allowin_out(id_allowin_out), .id_nextPC_out(id_nextPC_out),
    .id_rs_addr_out(id_rs_addr_out), .id_rt_addr_out(id_rt_addr_out),
    .rs_rdata_in(rs_rdata_in), .rt_rdata_in(rt_rdata_in), .id_stall_in(id_stall_in),
    .exe_allowin_in(exe_allowin_in), .id_valid_out(id_valid_out), .id_PC_out(id_PC_out),
    .id_Instruct_out(id_Instruct_out), .id_rs_data_out(id_rs_data_out),
    .id_rt_data_out(id_rt_data_out), .id_imm_out(id_imm_out), .id_link_out(id_link_out),
    .id_wreg_out(id_wreg_out), .id_wen_out(id_wen_out), .id_in_ds_out(id_in_ds_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction semantics as seen by decode: what it is, where it goes, what it writes.
  function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                                     input logic [31:0] npc, output bit br, output bit tk,
                                     output logic [31:0] tgt, output bit we, output logic [4:0] wr,
                                     output logic [31:0] imm);
    logic [5:0] op;
    int srs;
    op  = ins[31:26];
    srs = $signed(rs);
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) imm = {16'h0000, ins[15:0]};
    else imm = {{16{ins[15]}}, ins[15:0]};
    br = 0; tk = 0; we = 0; wr = ins[20:16];
    tgt = npc + imm * 4;
    case (op)
      6'h00: begin
        wr = ins[15:11];
        if (ins[5:0] == 6'h21 || ins[5:0] == 6'h23 || ins[5:0] == 6'h2A || ins[5:0] == 6'h00) we = 1;
        if (ins[5:0] == 6'h08 || ins[5:0] == 6'h09) begin br = 1; tk = 1; tgt = rs; we = (ins[5:0] == 6'h09); end
      end
      6'h01: begin
        wr = 31;
        case (ins[20:16])
          5'h00: begin br = 1; tk = (srs < 0); end
          5'h01: begin br = 1; tk = (srs >= 0); end
          5'h10: begin br = 1; tk = (srs < 0); we = 1; end
          5'h11: begin br = 1; tk = (srs >= 0); we = 1; end
          default: ;
        endcase
      end
      6'h02, 6'h03: begin
        br = 1; tk = 1; tgt = (npc & 32'hF000_0000) | (32'(ins[25:0]) << 2);
        if (op == 6'h03) begin we = 1; wr = 31; end
      end
      6'h04: begin br = 1; tk = (rs == rt); end
      6'h05: begin br = 1; tk = (rs != rt); end
      6'h06: begin br = 1; tk = (srs <= 0); end
      6'h07: begin br = 1; tk = (srs > 0); end
      6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: we = 1;
      default: ;
    endcase
  endfunction

  // Model of the ID slot plus an in-order scoreboard of PCs handed from fetch to EXE.
  bit          m_init = 0, m_valid = 0, m_inds = 0;
  logic [31:0] m_pc = 0, m_npc = 0, m_nnpc = 0, m_instr = 0;
  logic [31:0] q[$];

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_inds = 0; m_pc = 0; m_npc = 0; m_nnpc = 0; m_instr = 0;
      q.delete();
      m_init = 1;
    end else begin
      bit al, lv, br, tk, we;
      logic [31:0] tgt, imm;
      logic [4:0] wr;
      al = !m_valid || (!id_stall_in && exe_allowin_in);
      lv = m_valid && !id_stall_in && exe_allowin_in;
      if (lv) begin
        ref_decode(m_instr, 0, 0, m_npc, br, tk, tgt, we, wr, imm);
        m_inds = br;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (al) begin
        m_valid = if_valid_in;
        if (if_valid_in) begin
          m_pc = if_PC_in; m_npc = if_NPC_in; m_nnpc = if_NNPC_in; m_instr = if_Instruct_in;
          q.push_back(if_PC_in);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      bit br, tk, we, al;
      logic [31:0] tgt, imm, rsv, rtv;
      logic [4:0] wr;
      rsv = regs[m_instr[25:21]];
      rtv = regs[m_instr[20:16]];
      ref_decode(m_instr, rsv, rtv, m_npc, br, tk, tgt, we, wr, imm);
      al = !rst_n || !m_valid || (!id_stall_in && exe_allowin_in);
      chk("allowin", 32'(id_allowin_out), 32'(al));
      chk("valid", 32'(id_valid_out), 32'(m_valid && !id_stall_in));
      if (al) chk("nextpc", id_nextPC_out, (m_valid && tk) ? tgt : if_NPC_in);
      chk("in_ds", 32'(id_in_ds_out), 32'(m_inds));
      if (m_valid) begin
        chk("pc", id_PC_out, m_pc);
        chk("instr", id_Instruct_out, m_instr);
        chk("rs_addr", 32'(id_rs_addr_out), 32'(m_instr[25:21]));
        chk("rt_addr", 32'(id_rt_addr_out), 32'(m_instr[20:16]));
        chk("rs_data", id_rs_data_out, rsv);
        chk("rt_data", id_rt_data_out, rtv);
        chk("imm", id_imm_out, imm);
        chk("link", id_link_out, m_nnpc);
        chk("wen", 32'(id_wen_out), 32'(we));
        if (we) chk("wreg", 32'(id_wreg_out), 32'(wr));
      end
      if (id_valid_out && exe_allowin_in) begin
        if (q.size() > 0) chk("sb_order", id_PC_out, q[0]);
        else begin
          checks++; errors++;
          $display("FAIL sb_order actual=transfer of %08h expected=no pending instruction", id_PC_out);
        end
      end
    end
  end

  task automatic fetch(input bit v, input logic [31:0] pc, input logic [31:0] ins);
    if_valid_in = v; if_PC_in = pc; if_NPC_in = pc + 4; if_NNPC_in = pc + 8; if_Instruct_in = ins;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return 32'h0000_0005;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] jt;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 31));
    jt = 26'($urandom());
    case ($urandom_range(0, 4))
      0: imm = 16'h0000; 1: imm = 16'h7FFF; 2: imm = 16'h8000; 3: imm = 16'hFFFF;
      default: imm = 16'($urandom());
    endcase
    case ($urandom_range(0, 24))
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      2:  return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      3:  return {6'h00, 5'd0, rt, rd, 5'd3, 6'h00};
      4:  return {6'h00, rs, 15'd0, 6'h08};
      5:  return {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
      6:  return {6'h00, rs, rt, 10'd0, 6'h18};
      7:  return {6'h00, 20'd0, 6'h0C};
      8:  return {6'h09, rs, rt, imm};
      9:  return {6'h0C, rs, rt, imm};
      10: return {6'h0D, rs, rt, imm};
      11: return {6'h0E, rs, rt, imm};
      12: return {6'h0F, 5'd0, rt, imm};
      13: return {6'h23, rs, rt, imm};
      14: return {6'h2B, rs, rt, imm};
      15: return {6'h04, rs, rt, imm};
      16: return {6'h05, rs, rt, imm};
      17: return {6'h06, rs, 5'd0, imm};
      18: return {6'h07, rs, 5'd0, imm};
      19: return {6'h01, rs, 5'($urandom_range(0, 1)), imm};
      20: return {6'h01, rs, 5'($urandom_range(16, 17)), imm};
      21: return {6'h01, rs, 5'h02, imm};
      22: return {6'h02, jt};
      23: return {6'h03, jt};
      default: return ($urandom_range(0, 1) == 0) ? {6'h3F, jt} : {6'h00, rs, rt, rd, 5'd0, 6'h01};
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    rst_n = 0; id_stall_in = 0; exe_allowin_in = 1;
    fetch(0, 32'h0000_1000, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(id_valid_out), 32'h0);
    chk("rst_allowin", 32'(id_allowin_out), 32'h1);
    chk("rst_nextpc", id_nextPC_out, 32'h0000_1004);

    tick();
    rst_n = 1;
    regs[1] = 32'h11; regs[2] = 32'h22; regs[5] = 32'h5; regs[6] = 32'h8000_0000;
    fetch(1, 32'hBFC0_0000, 32'h0022_1821);            // ADDU $3,$1,$2
    tick();
    fetch(1, 32'h0000_0100, 32'h10A5_0004);            // BEQ $5,$5,+4
    @(negedge clk);
    chk("addu_valid", 32'(id_valid_out), 32'h1);
    chk("addu_wreg", 32'(id_wreg_out), 32'h3);
    chk("addu_wen", 32'(id_wen_out), 32'h1);
    tick();
    fetch(1, 32'h0000_0104, 32'h0);                    // delay-slot NOP
    @(negedge clk);
    chk("beq_nextpc", id_nextPC_out, 32'h0000_0114);
    tick();
    fetch(1, 32'h0000_0114, 32'h14A5_0004);            // BNE $5,$5,+4
    @(negedge clk);
    chk("ds_flag", 32'(id_in_ds_out), 32'h1);
    tick();
    fetch(1, 32'h0000_0200, 32'h0C00_0100);            // JAL 0x400
    @(negedge clk);
    chk("bne_nextpc", id_nextPC_out, 32'h0000_0204);
    chk("ds_clear", 32'(id_in_ds_out), 32'h0);
    tick();
    fetch(0, 32'h0000_0208, 32'h0);
    @(negedge clk);
    chk("jal_link", id_link_out, 32'h0000_0208);
    chk("jal_wreg", 32'(id_wreg_out), 32'd31);
    chk("jal_nextpc", id_nextPC_out, 32'h0000_0400);

    tick();
    fetch(1, 32'h0000_0300, 32'h2443_0007);            // ADDIU $3,$2,7
    tick();
    id_stall_in = 1;
    fetch(1, 32'h0000_0304, 32'h34A5_FFFF);            // ORI $5,$5,0xFFFF
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_allowin", 32'(id_allowin_out), 32'h0);
      chk("stall_valid", 32'(id_valid_out), 32'h0);
      chk("stall_pc", id_PC_out, 32'h0000_0300);
      tick();
    end
    id_stall_in = 0;
    @(negedge clk);
    chk("release_valid", 32'(id_valid_out), 32'h1);
    tick();
    fetch(1, 32'h0000_0400, 32'h04C0_0008);            // BLTZ $6,+8
    @(negedge clk);
    chk("ori_pc", id_PC_out, 32'h0000_0304);
    chk("ori_imm", id_imm_out, 32'h0000_FFFF);
    tick();
    exe_allowin_in = 0;
    fetch(1, 32'h0000_0404, 32'hACC7_0000);            // SW $7,0($6)
    @(negedge clk);
    chk("hold_allowin", 32'(id_allowin_out), 32'h0);
    tick();
    @(negedge clk);
    chk("hold_pc", id_PC_out, 32'h0000_0400);
    chk("hold_instr", id_Instruct_out, 32'h04C0_0008);
    tick();
    exe_allowin_in = 1;
    @(negedge clk);
    chk("bltz_nextpc", id_nextPC_out, 32'h0000_0424);
    tick();
    fetch(0, 32'h0000_0424, 32'h0);
    @(negedge clk);
    chk("sw_pc", id_PC_out, 32'h0000_0404);
    chk("sw_ds", 32'(id_in_ds_out), 32'h1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [31:0] pc;
      tick();
      if (cyc % 40 == 0)
        for (int r = 0; r < 32; r++) regs[r] = pick_val();
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 1) * 4)
                                        : ($urandom() & 32'hFFFF_FFFC);
      rst_n          = ($urandom_range(0, 149) != 0);
      id_stall_in    = ($urandom_range(0, 4) == 0);
      exe_allowin_in = ($urandom_range(0, 4) != 0);
      fetch($urandom_range(0, 3) != 0, pc, rnd_instr());
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
